// File: rtl/rx_pkg.sv
// rx_pkg: shared types and helpers for the HP video capture path.
// Used by rx_timing and rx_frame_writer.
package rx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_FRAME,
      ACTIVE,
      DONE
   } rx_state_e;

   localparam logic SYNC_ACTIVE = 1'b0;

   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/rx_timing.sv
// rx_timing: sync registers, deassert-edge detect, x/y position
// counters and the active-window flag for the capture stage.
module rx_timing
   import rx_pkg::*;
#(
   parameter int H_OFFSET = 64,
   parameter int H_ACTIVE = 512,
   parameter int V_OFFSET = 8,
   parameter int V_ACTIVE = 32
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic hs_i,
   input  logic vs_i,
   output logic vs_edge_o,
   output logic visible_o,
   output logic last_o
);

   localparam int XW = cnt_w(H_OFFSET + H_ACTIVE);
   localparam int YW = cnt_w(V_OFFSET + V_ACTIVE);

   localparam logic [XW-1:0] X_LO   = XW'(H_OFFSET);
   localparam logic [XW-1:0] X_HI   = XW'(H_OFFSET + H_ACTIVE);
   localparam logic [XW-1:0] X_LAST = XW'(H_OFFSET + H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_LO   = YW'(V_OFFSET);
   localparam logic [YW-1:0] Y_HI   = YW'(V_OFFSET + V_ACTIVE);
   localparam logic [YW-1:0] Y_LAST = YW'(V_OFFSET + V_ACTIVE - 1);

   logic          hs_q;
   logic          vs_q;
   logic          hs_edge;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   assign hs_edge   = (hs_q == SYNC_ACTIVE) && (hs_i != SYNC_ACTIVE);
   assign vs_edge_o = (vs_q == SYNC_ACTIVE) && (vs_i != SYNC_ACTIVE);

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (hs_edge) begin
         x_d = '0;
      end else if (x_q != X_HI) begin
         x_d = x_q + 1'b1;
      end
      // Frame edge takes priority over a coincident line edge
      if (vs_edge_o) begin
         y_d = '0;
      end else if (hs_edge && (y_q != Y_HI)) begin
         y_d = y_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hs_q <= ~SYNC_ACTIVE;
         vs_q <= ~SYNC_ACTIVE;
         x_q  <= '0;
         y_q  <= '0;
      end else begin
         hs_q <= hs_i;
         vs_q <= vs_i;
         x_q  <= x_d;
         y_q  <= y_d;
      end
   end

   assign visible_o = (x_q >= X_LO) && (x_q < X_HI) &&
                      (y_q >= Y_LO) && (y_q < Y_HI);
   assign last_o    = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/rx_frame_writer.sv
// rx_frame_writer: frame FSM writing the visible window to BRAM.
// Optional RX_FRAME_COUNT_EN adds FRAME_WORDS and FRAME_CNT outputs.
module rx_frame_writer
   import rx_pkg::*;
#(
   parameter int PIX_W    = 10,
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 14,
   parameter int DEPTH    = 16384,
   parameter int H_OFFSET = 64,
   parameter int H_ACTIVE = 512,
   parameter int V_OFFSET = 8,
   parameter int V_ACTIVE = 32
) (
   input  logic              O_CLK,
   input  logic              O_RST_N,
   input  logic              ENABLE,
   input  logic              O_HS,
   input  logic              O_VS,
   input  logic [PIX_W-1:0]  VIDEO,
   output logic [DATA_W-1:0] BRAM_DIN,
   output logic [ADDR_W-1:0] BRAM_ADDR,
   output logic              BRAM_WE,
   output logic              O_VISIBLE,
   output logic              FRAME_START,
   output logic              FRAME_DONE,
   output logic              SYNC_ERR,
   output logic              OVERFLOW
`ifdef RX_FRAME_COUNT_EN
   ,
   output logic [ADDR_W:0]   FRAME_WORDS,
   output logic [15:0]       FRAME_CNT
`endif
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);

   logic vs_edge;
   logic visible;
   logic last;

   rx_timing #(
      .H_OFFSET (H_OFFSET),
      .H_ACTIVE (H_ACTIVE),
      .V_OFFSET (V_OFFSET),
      .V_ACTIVE (V_ACTIVE)
   ) u_timing (
      .clk_i     (O_CLK),
      .rst_ni    (O_RST_N),
      .hs_i      (O_HS),
      .vs_i      (O_VS),
      .vs_edge_o (vs_edge),
      .visible_o (visible),
      .last_o    (last)
   );

   rx_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   wcnt_q, wcnt_d;
   logic [DATA_W-1:0] din_q;
   logic              vis_q;
   logic              we_q, we_d;
   logic              start_q, start_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              ovf_q, ovf_d;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wcnt_d  = wcnt_q;
      we_d    = 1'b0;
      start_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      ovf_d   = ovf_q;
      // Address parks on the last word once the buffer is full
      if (we_q && (addr_q != ADDR_LAST)) begin
         addr_d = addr_q + 1'b1;
      end
      if (!ENABLE) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: state_d = WAIT_FRAME;
            WAIT_FRAME: begin
               if (vs_edge) begin
                  state_d = ACTIVE;
                  start_d = 1'b1;
                  addr_d  = '0;
                  wcnt_d  = '0;
                  ovf_d   = 1'b0;
               end
            end
            ACTIVE: begin
               if (O_VS == SYNC_ACTIVE) begin
                  err_d   = 1'b1;
                  state_d = WAIT_FRAME;
               end else if (visible) begin
                  if (wcnt_q != DEPTH_W) begin
                     we_d   = 1'b1;
                     wcnt_d = wcnt_q + 1'b1;
                  end else begin
                     ovf_d = 1'b1;
                  end
                  if (last) state_d = DONE;
               end
            end
            DONE: begin
               done_d  = 1'b1;
               state_d = WAIT_FRAME;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge O_CLK or negedge O_RST_N) begin
      if (!O_RST_N) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wcnt_q  <= '0;
         din_q   <= '0;
         vis_q   <= 1'b0;
         we_q    <= 1'b0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wcnt_q  <= wcnt_d;
         din_q   <= VIDEO[PIX_W-1 -: DATA_W];
         vis_q   <= visible;
         we_q    <= we_d;
         start_q <= start_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
      end
   end

   assign BRAM_DIN    = din_q;
   assign BRAM_ADDR   = addr_q;
   assign BRAM_WE     = we_q;
   assign O_VISIBLE   = vis_q;
   assign FRAME_START = start_q;
   assign FRAME_DONE  = done_q;
   assign SYNC_ERR    = err_q;
   assign OVERFLOW    = ovf_q;

`ifdef RX_FRAME_COUNT_EN
   logic [ADDR_W:0] words_q;
   logic [15:0]     fcnt_q;

   always_ff @(posedge O_CLK or negedge O_RST_N) begin
      if (!O_RST_N) begin
         words_q <= '0;
         fcnt_q  <= '0;
      end else if (done_d) begin
         words_q <= wcnt_q;
         fcnt_q  <= fcnt_q + 1'b1;
      end
   end

   assign FRAME_WORDS = words_q;
   assign FRAME_CNT   = fcnt_q;
`endif

endmodule

// File: doc/rx_frame_writer.md
Name: rx_frame_writer

Overview:
Parametrised capture stage for the HP video input. Tracks line/frame position from O_HS/O_VS, windows the active region, truncates each visible pixel to the frame-buffer width and writes it to BRAM at a linearly incrementing address. Adds what the first-generation receiver lacked: configurable geometry and widths, a frame FSM, overflow protection, and frame start/done/error strobes for the display side.

Parameters:
PIX_W, 10, VIDEO input width
DATA_W, 8, BRAM word width; must be <= PIX_W
ADDR_W, 14, BRAM address width
DEPTH, 16384, usable BRAM words; must be <= 2**ADDR_W
H_OFFSET, 64, pixel clocks from HS deassert to first visible pixel
H_ACTIVE, 512, visible pixels per line
V_OFFSET, 8, lines from VS deassert to first visible line
V_ACTIVE, 32, visible lines per frame

Ports:
O_CLK  in  1  pixel clock; all logic on rising edge
O_RST_N  in  1  asynchronous, active-low reset
ENABLE  in  1  capture enable
O_HS  in  1  horizontal sync, active-low, O_CLK domain
O_VS  in  1  vertical sync, active-low, O_CLK domain
VIDEO  in  PIX_W  pixel sample
BRAM_DIN  out  DATA_W  write data = registered VIDEO[PIX_W-1 -: DATA_W]
BRAM_ADDR  out  ADDR_W  write address
BRAM_WE  out  1  write strobe
O_VISIBLE  out  1  registered active-window flag
FRAME_START  out  1  one-cycle pulse on frame arm
FRAME_DONE  out  1  one-cycle pulse after last visible write
SYNC_ERR  out  1  one-cycle pulse on frame abort
OVERFLOW  out  1  sticky per frame; write suppressed at DEPTH

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0.
- O_HS/O_VS registered once; deassert edge = registered 0, current 1.
- x: cleared to 0 on HS deassert edge, else increments, saturating at H_OFFSET+H_ACTIVE.
- y: cleared on VS deassert edge, increments on each HS deassert edge, saturating at V_OFFSET+V_ACTIVE.
- VS edge and HS edge in same cycle: VS wins, y=0.
- visible = H_OFFSET<=x<H_OFFSET+H_ACTIVE and V_OFFSET<=y<V_OFFSET+V_ACTIVE.
- FSM IDLE: waits for ENABLE=1 -> WAIT_FRAME.
- WAIT_FRAME: on VS deassert edge -> ACTIVE; FRAME_START=1; BRAM_ADDR=0; OVERFLOW cleared.
- ACTIVE: every visible cycle issues a write. Latency 1: pixel sampled at cycle t yields BRAM_DIN/BRAM_WE/O_VISIBLE at t+1. BRAM_ADDR holds the current write address and increments the cycle after each write.
- Visible write with BRAM_ADDR = DEPTH-1 is performed; later visible cycles in that frame: BRAM_WE=0, address holds, OVERFLOW=1.
- ACTIVE: after the final visible pixel (x = H_OFFSET+H_ACTIVE-1, y = V_OFFSET+V_ACTIVE-1) is written -> DONE.
- DONE: FRAME_DONE=1 for one cycle -> WAIT_FRAME.
- O_VS asserted while in ACTIVE before DONE: SYNC_ERR=1 for one cycle -> WAIT_FRAME. No FRAME_DONE. BRAM_ADDR not cleared until the next arm.
- ENABLE=0 in any state: next cycle IDLE, BRAM_WE=0, no strobes. Partial frame discarded.
- Async reset mid-write: BRAM_WE drops immediately.

Optional Feature:
RX_FRAME_COUNT_EN
- Defined: adds output FRAME_WORDS [ADDR_W:0], latched at FRAME_DONE with the number of writes performed that frame, reset 0. Also adds FRAME_CNT [15:0], incremented per FRAME_DONE, wrapping at 65535->0.
- Undefined: neither port nor its registers exist; all other behaviour identical.

Decomposition:
- Package rx_pkg: FSM state enum (IDLE, WAIT_FRAME, ACTIVE, DONE); SYNC_ACTIVE=1'b0 constant; clog2-based counter-width helper.
- Sub-module rx_timing: sync registers, edge detect, x/y counters, visible flag.
- rx_frame_writer: FSM, address, WE, overflow and strobes.

Test Plan:
Bench parameters: H_OFFSET=2, H_ACTIVE=4, V_OFFSET=1, V_ACTIVE=3, DEPTH=16, PIX_W=10, DATA_W=8.
1. Full frame, VIDEO=x counter -> 12 writes at addresses 0..11; BRAM_DIN = VIDEO[9:2]; FRAME_DONE one cycle after write at address 11.
2. DEPTH=8, same frame -> writes at 0..7 only; OVERFLOW=1 from the 9th visible cycle; FRAME_DONE still pulses; next FRAME_START clears OVERFLOW.
3. VS asserted after line 2 -> SYNC_ERR pulse, no FRAME_DONE; next frame restarts at address 0.
4. ENABLE dropped mid-line -> BRAM_WE=0 next cycle, FSM IDLE. ENABLE re-raised -> nothing written until the next VS deassert edge.
5. O_RST_N pulsed low during a write -> BRAM_WE and BRAM_ADDR go to 0 asynchronously; all strobes 0.
6. VS and HS deassert edges in the same cycle -> y=0; first write occurs on the line after V_OFFSET, with pixel x=2.
